// File: rtl/layer_mac_scheduler.sv
// Layer controller: walks every (neuron, input) pair through one shared MAC/bias-add datapath,
// handshakes each operation, strobes activated results out and answers the layer req/ack.
module layer_mac_scheduler #(
    parameter int unsigned N_IN      = 2,
    parameter int unsigned N_OUT     = 2,
    parameter int unsigned TO_CYCLES = 15,
    parameter int unsigned IW        = $clog2((N_IN > 2) ? N_IN : 2),
    parameter int unsigned NW        = $clog2((N_OUT > 2) ? N_OUT : 2),
    parameter int unsigned AW        = $clog2((N_IN * N_OUT > 2) ? N_IN * N_OUT : 2)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    output logic          ack_layer,
    output logic          err,
    output logic [IW-1:0] in_idx,
    output logic [NW-1:0] neu_idx,
    output logic [AW-1:0] w_addr,
    output logic [NW-1:0] b_addr,
    output logic          acc_clr,
    output logic          mac_req,
    input  logic          mac_ack,
    output logic          add_req,
    input  logic          add_ack,
    output logic          out_we,
    output logic [NW-1:0] out_idx
);
    localparam int unsigned TW = $clog2(TO_CYCLES);
    localparam logic [IW-1:0] InLast   = IW'(N_IN - 1);
    localparam logic [NW-1:0] NeuLast  = NW'(N_OUT - 1);
    localparam logic [TW-1:0] WaitLast = TW'(TO_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle, StClr, StAddr, StMac, StBias, StWrite, StDone, StErr
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] in_q, in_d;
    logic [NW-1:0] neu_q, neu_d;
    logic [TW-1:0] wait_q, wait_d;
    logic          err_q, err_d;
    logic [AW-1:0] w_addr_q, w_addr_d;
    logic          ack_layer_q, ack_layer_d;
    logic          acc_clr_q, acc_clr_d;
    logic          mac_req_q, mac_req_d;
    logic          add_req_q, add_req_d;
    logic          out_we_q, out_we_d;

    always_comb begin
        state_d = state_q;
        in_d    = in_q;
        neu_d   = neu_q;
        wait_d  = wait_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    err_d   = 1'b0;
                    neu_d   = '0;
                    in_d    = '0;
                    state_d = StClr;
                end
            end
            StClr: begin
                in_d    = '0;
                state_d = StAddr;
            end
            StAddr: begin
                wait_d  = '0;
                state_d = StMac;
            end
            StMac: begin
                // An ack arriving on the expiry cycle still completes the operation.
                if (mac_ack) begin
                    if (in_q == InLast) begin
                        wait_d  = '0;
                        state_d = StBias;
                    end else begin
                        in_d    = in_q + 1'b1;
                        state_d = StAddr;
                    end
                end else if (wait_q == WaitLast) begin
                    err_d   = 1'b1;
                    state_d = StErr;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StBias: begin
                if (add_ack) begin
                    state_d = StWrite;
                end else if (wait_q == WaitLast) begin
                    err_d   = 1'b1;
                    state_d = StErr;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StWrite: begin
                if (neu_q == NeuLast) begin
                    state_d = StDone;
                end else begin
                    neu_d   = neu_q + 1'b1;
                    state_d = StClr;
                end
            end
            StDone, StErr: begin
                if (!req) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from the next state so they line up with it.
        acc_clr_d   = (state_d == StClr);
        mac_req_d   = (state_d == StMac);
        add_req_d   = (state_d == StBias);
        out_we_d    = (state_d == StWrite);
        ack_layer_d = (state_d == StDone) || (state_d == StErr);
        w_addr_d    = AW'(neu_d) * AW'(N_IN) + AW'(in_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            in_q        <= '0;
            neu_q       <= '0;
            wait_q      <= '0;
            err_q       <= 1'b0;
            w_addr_q    <= '0;
            ack_layer_q <= 1'b0;
            acc_clr_q   <= 1'b0;
            mac_req_q   <= 1'b0;
            add_req_q   <= 1'b0;
            out_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_q        <= in_d;
            neu_q       <= neu_d;
            wait_q      <= wait_d;
            err_q       <= err_d;
            w_addr_q    <= w_addr_d;
            ack_layer_q <= ack_layer_d;
            acc_clr_q   <= acc_clr_d;
            mac_req_q   <= mac_req_d;
            add_req_q   <= add_req_d;
            out_we_q    <= out_we_d;
        end
    end

    assign ack_layer = ack_layer_q;
    assign err       = err_q;
    assign in_idx    = in_q;
    assign neu_idx   = neu_q;
    assign w_addr    = w_addr_q;
    assign b_addr    = neu_q;
    assign acc_clr   = acc_clr_q;
    assign mac_req   = mac_req_q;
    assign add_req   = add_req_q;
    assign out_we    = out_we_q;
    assign out_idx   = neu_q;

endmodule

// File: tb/tb_layer_mac_scheduler.sv
// Bench for layer_mac_scheduler: a schedule model turns per-operation ack delays and req/rst
// plans into a cycle-by-cycle expectation queue that drives inputs and checks every output.
module tb_layer_mac_scheduler;
    localparam int N_IN  = 2;
    localparam int N_OUT = 2;
    localparam int TO    = 15;
    localparam int IW    = $clog2((N_IN > 2) ? N_IN : 2);
    localparam int NW    = $clog2((N_OUT > 2) ? N_OUT : 2);
    localparam int AW    = $clog2((N_IN * N_OUT > 2) ? N_IN * N_OUT : 2);

    logic          clk = 1'b0;
    logic          rst, req, mac_ack, add_ack;
    logic          ack_layer, err, acc_clr, mac_req, add_req, out_we;
    logic [IW-1:0] in_idx;
    logic [NW-1:0] neu_idx, b_addr, out_idx;
    logic [AW-1:0] w_addr;

    layer_mac_scheduler #(
        .N_IN(N_IN), .N_OUT(N_OUT), .TO_CYCLES(TO), .IW(IW), .NW(NW), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .ack_layer(ack_layer), .err(err),
        .in_idx(in_idx), .neu_idx(neu_idx), .w_addr(w_addr), .b_addr(b_addr),
        .acc_clr(acc_clr), .mac_req(mac_req), .mac_ack(mac_ack), .add_req(add_req),
        .add_ack(add_ack), .out_we(out_we), .out_idx(out_idx)
    );

    initial forever #5 clk = ~clk;

    // One cycle: inputs to drive, outputs expected, and which index outputs matter.
    typedef struct packed {
        logic req, rst, mack, aack;
        logic e_ack, e_err, e_clr, e_mreq, e_areq, e_we;
        logic c_in, c_neu, c_b, c_out;
        int   in_v, neu_v, w_v, b_v, out_v;
    } cyc_t;

    cyc_t q[$];
    int   mdly[N_IN*N_OUT];
    int   adly[N_OUT];
    int   n_chk = 0, n_err = 0, cur_cyc = 0;
    int   spur, drop_at, hold, rst_at, rel;
    bit   m_err, ab, after_rst;
    int   st_clr, st_we, st_ack, st_ackn, st_err, st_err0;
    int   wseq[$], oseq[$];

    task automatic chk(input string nm, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0d, want %0d", nm, cur_cyc, got, want);
        end
    endtask

    function automatic cyc_t noise(input cyc_t ci, input bit m, input bit a);
        cyc_t c;
        c = ci;
        if (m && $urandom_range(0, 99) < spur) c.mack = 1'b1;
        if (a && $urandom_range(0, 99) < spur) c.aack = 1'b1;
        return c;
    endfunction

    function automatic cyc_t base(input int n);
        cyc_t c;
        c       = '0;
        c.c_neu = 1'b1;
        c.neu_v = n;
        c.req   = (drop_at < 0) || (rel < drop_at);
        return c;
    endfunction

    task automatic put(input cyc_t ci);
        cyc_t c;
        c = ci;
        if (rel == rst_at) begin
            c.rst     = 1'b1;
            ab        = 1'b1;
            m_err     = 1'b0;
            after_rst = 1'b1;
        end
        rel++;
        q.push_back(c);
    endtask

    task automatic push_idle(input logic r);
        cyc_t c;
        c       = '0;
        c.req   = r;
        c.e_err = m_err;
        if (after_rst) begin
            c.c_in = 1'b1; c.c_neu = 1'b1; c.c_b = 1'b1; c.c_out = 1'b1;
            after_rst = 1'b0;
        end
        q.push_back(noise(c, 1'b1, 1'b1));
    endtask

    task automatic finish_run(input bit e);
        cyc_t c;
        int   k;
        k     = 0;
        m_err = e;
        forever begin
            c       = '0;
            c.e_ack = 1'b1;
            c.e_err = e;
            c.req   = (drop_at < 0) ? (k < hold) : (rel < drop_at);
            c       = noise(c, 1'b1, 1'b1);
            put(c);
            if (ab || !c.req) break;
            k++;
        end
    endtask

    // Expected schedule of one run: start cycle, per neuron CLR, (ADDR, MAC*d) per input,
    // BIAS*d, WRITE, then DONE/ERR held for as long as req stays high.
    task automatic build_run(input int drop, input int h, input int rsta);
        cyc_t c;
        int   d, len;
        bit   to;
        drop_at = drop; hold = h; rst_at = rsta;
        push_idle(1'b1);
        m_err = 1'b0; rel = 0; ab = 1'b0;
        for (int n = 0; n < N_OUT; n++) begin
            c = base(n); c.e_clr = 1'b1;
            put(noise(c, 1'b1, 1'b1)); if (ab) return;
            for (int i = 0; i < N_IN; i++) begin
                c = base(n); c.c_in = 1'b1; c.in_v = i; c.w_v = n * N_IN + i;
                put(noise(c, 1'b1, 1'b1)); if (ab) return;
                d   = mdly[n*N_IN+i];
                to  = (d < 1) || (d > TO);
                len = to ? TO : d;
                for (int j = 1; j <= len; j++) begin
                    c = base(n); c.c_in = 1'b1; c.in_v = i; c.w_v = n * N_IN + i;
                    c.e_mreq = 1'b1;
                    c.mack   = !to && (j == d);
                    put(noise(c, 1'b0, 1'b1)); if (ab) return;
                end
                if (to) begin
                    finish_run(1'b1);
                    return;
                end
            end
            d   = adly[n];
            to  = (d < 1) || (d > TO);
            len = to ? TO : d;
            for (int j = 1; j <= len; j++) begin
                c = base(n); c.c_b = 1'b1; c.b_v = n; c.e_areq = 1'b1;
                c.aack = !to && (j == d);
                put(noise(c, 1'b1, 1'b0)); if (ab) return;
            end
            if (to) begin
                finish_run(1'b1);
                return;
            end
            c = base(n); c.e_we = 1'b1; c.c_out = 1'b1; c.out_v = n;
            put(noise(c, 1'b1, 1'b1)); if (ab) return;
        end
        finish_run(1'b0);
    endtask

    task automatic set_dly(input int md, input int ad);
        for (int i = 0; i < N_IN * N_OUT; i++) mdly[i] = md;
        for (int i = 0; i < N_OUT; i++) adly[i] = ad;
    endtask

    // Drive and check the queued cycles; statistics index 0 is the first queued cycle.
    task automatic run_q();
        cyc_t c;
        int   idx;
        logic prev_mreq;
        idx = 0; prev_mreq = 1'b0;
        st_clr = 0; st_we = 0; st_ack = -1; st_ackn = 0; st_err = -1; st_err0 = -1;
        wseq.delete(); oseq.delete();
        while (q.size() > 0) begin
            c = q.pop_front();
            rst = c.rst; req = c.req; mac_ack = c.mack; add_ack = c.aack;
            chk("ack_layer", int'(ack_layer), int'(c.e_ack));
            chk("err", int'(err), int'(c.e_err));
            chk("acc_clr", int'(acc_clr), int'(c.e_clr));
            chk("mac_req", int'(mac_req), int'(c.e_mreq));
            chk("add_req", int'(add_req), int'(c.e_areq));
            chk("out_we", int'(out_we), int'(c.e_we));
            if (c.c_in) begin
                chk("in_idx", int'(in_idx), c.in_v);
                chk("w_addr", int'(w_addr), c.w_v);
            end
            if (c.c_neu) chk("neu_idx", int'(neu_idx), c.neu_v);
            if (c.c_b) chk("b_addr", int'(b_addr), c.b_v);
            if (c.c_out) chk("out_idx", int'(out_idx), c.out_v);
            if (idx == 0) st_err0 = int'(err);
            if (acc_clr) st_clr++;
            if (out_we) begin
                st_we++;
                oseq.push_back(int'(out_idx));
            end
            if (ack_layer) begin
                st_ackn++;
                if (st_ack < 0) begin
                    st_ack = idx;
                    st_err = int'(err);
                end
            end
            if (mac_req && !prev_mreq) wseq.push_back(int'(w_addr));
            prev_mreq = mac_req;
            @(posedge clk);
            #1;
            idx++;
            cur_cyc++;
        end
    endtask

    initial begin
        cyc_t c;
        int   drop, h, rsta;
        rst = 1'b1; req = 1'b0; mac_ack = 1'b0; add_ack = 1'b0;
        m_err = 1'b0; ab = 1'b0; after_rst = 1'b0; spur = 0;
        drop_at = -1; hold = 0; rst_at = -1; rel = 0;
        @(posedge clk);
        #1;

        // Reset state, then nominal run with 1-cycle responders.
        c = '0; c.rst = 1'b1; c.c_in = 1'b1; c.c_neu = 1'b1; c.c_b = 1'b1; c.c_out = 1'b1;
        q.push_back(c);
        after_rst = 1'b1;
        push_idle(1'b0);
        run_q();
        set_dly(2, 2);
        build_run(-1, 1, -1);
        push_idle(1'b0);
        run_q();
        chk("nom_ack_cycle", st_ack, 21);
        chk("nom_acc_clr", st_clr, 2);
        chk("nom_out_we", st_we, 2);
        chk("nom_err", st_err, 0);
        chk("nom_waddr_n", wseq.size(), 4);
        for (int i = 0; i < wseq.size() && i < 4; i++) chk("nom_waddr_seq", wseq[i], i);
        chk("nom_outidx_n", oseq.size(), 2);
        for (int i = 0; i < oseq.size() && i < 2; i++) chk("nom_outidx_seq", oseq[i], i);

        // Slow MAC responder: 5 cycles of mac_req per operation.
        set_dly(5, 2);
        build_run(-1, 0, -1);
        push_idle(1'b0);
        run_q();
        chk("slow_ack_cycle", st_ack, 33);
        chk("slow_out_we", st_we, 2);

        // Timeout on w_addr=2, then a fresh run clears err.
        set_dly(2, 2);
        mdly[2] = 0;
        build_run(-1, 0, -1);
        push_idle(1'b0);
        run_q();
        chk("to_ack_cycle", st_ack, 28);
        chk("to_err", st_err, 1);
        chk("to_out_we", st_we, 1);
        set_dly(2, 2);
        build_run(-1, 0, -1);
        push_idle(1'b0);
        run_q();
        chk("to_err_held", st_err0, 1);
        chk("to_rerun_err", st_err, 0);
        chk("to_rerun_ack", st_ack, 21);

        // Reset in neuron 0 BIAS, then a full nominal run.
        build_run(-1, 0, 7);
        push_idle(1'b0);
        push_idle(1'b0);
        build_run(-1, 0, -1);
        push_idle(1'b0);
        run_q();
        chk("rst_ack_cycle", st_ack, 32);
        chk("rst_out_we", st_we, 2);
        chk("rst_acc_clr", st_clr, 3);

        // req dropped in neuron 1, ack on the expiry cycle, spurious acks everywhere.
        set_dly(2, 2);
        mdly[0] = TO;
        spur    = 100;
        build_run(25, 0, -1);
        push_idle(1'b0);
        run_q();
        chk("hs_ack_cycle", st_ack, 34);
        chk("hs_ack_len", st_ackn, 1);
        chk("hs_err", st_err, 0);
        chk("hs_out_we", st_we, 2);
        spur = 0;

        // Back-to-back runs.
        set_dly(2, 2);
        build_run(-1, 1, -1);
        build_run(-1, 0, -1);
        push_idle(1'b0);
        run_q();
        chk("b2b_acc_clr", st_clr, 4);
        chk("b2b_out_we", st_we, 4);
        chk("b2b_waddr_n", wseq.size(), 8);
        for (int i = 0; i < wseq.size() && i < 8; i++) chk("b2b_waddr_seq", wseq[i], i % 4);

        // Randomized runs.
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N_IN * N_OUT; i++) begin
                mdly[i] = $urandom_range(1, 6);
                if ($urandom_range(0, 99) < 8) mdly[i] = 0;
                else if ($urandom_range(0, 99) < 6) mdly[i] = TO;
                else if ($urandom_range(0, 99) < 4) mdly[i] = TO + 1;
            end
            for (int i = 0; i < N_OUT; i++) begin
                adly[i] = $urandom_range(1, 6);
                if ($urandom_range(0, 99) < 8) adly[i] = 0;
                else if ($urandom_range(0, 99) < 6) adly[i] = TO;
            end
            spur = $urandom_range(0, 30);
            if ($urandom_range(0, 1) == 0) begin
                drop = -1;
                h    = $urandom_range(0, 3);
            end else begin
                drop = $urandom_range(0, 40);
                h    = 0;
            end
            rsta = ($urandom_range(0, 99) < 10) ? $urandom_range(0, 30) : -1;
            build_run(drop, h, rsta);
            for (int g = $urandom_range(0, 2); g > 0; g--) push_idle(1'b0);
        end
        push_idle(1'b0);
        run_q();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/layer_mac_scheduler.md
Name: layer_mac_scheduler

Overview:
Controller that runs one fully-connected layer through a single shared MAC/bias-add datapath. It steps over every (neuron, input) pair, addresses the weight and bias ROMs, selects the input operand and handshakes each MAC and bias-add operation. It then strobes each activated result into the layer output register and returns the layer-level req/ack handshake to the network sequencer. The block sits between the network-level sequencer and one layer's datapath (weight ROM, accumulator, bias adder, activation function).

Parameters:
N_IN, 2, inputs per neuron (>=1)
N_OUT, 2, neurons in the layer (>=1)
TO_CYCLES, 15, maximum cycles to wait for mac_ack/add_ack before error (>=2)
IW, clog2(max(N_IN,2)), input index width
NW, clog2(max(N_OUT,2)), neuron index width
AW, clog2(max(N_IN*N_OUT,2)), weight address width

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous active-high reset
req  in  1  layer start request from network sequencer (level)
ack_layer  out  1  layer done/aborted, held while req high
err  out  1  handshake timeout occurred in last run
in_idx  out  IW  input operand select for MAC
neu_idx  out  NW  current neuron
w_addr  out  AW  weight ROM address = neu_idx*N_IN + in_idx
b_addr  out  NW  bias ROM address (= neu_idx)
acc_clr  out  1  clear accumulator (1-cycle pulse)
mac_req  out  1  request one multiply-accumulate
mac_ack  in  1  MAC done (1-cycle pulse)
add_req  out  1  request bias add
add_ack  in  1  bias add done (1-cycle pulse)
out_we  out  1  write activated value to output slot out_idx (1-cycle pulse)
out_idx  out  NW  output slot being written

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst. When rst is sampled high: state=IDLE, all outputs 0, counters 0. Reset wins over every other event, including mid-operation; no partial out_we is issued.
- All outputs are registered (Moore). ROM reads happen on the falling edge, so w_addr and b_addr are driven one state before their data is consumed.
- States and transitions:
  - IDLE: when req=1, clear err, neu=0, go to CLR.
  - CLR: acc_clr=1 for 1 cycle, in=0, go to ADDR.
  - ADDR: w_addr and in_idx valid, 1 cycle (weight fetch settles), go to MAC.
  - MAC: mac_req=1 until mac_ack sampled. On mac_ack: if in==N_IN-1 go to BIAS, else in+1 and go to ADDR.
  - BIAS: b_addr valid, add_req=1 until add_ack sampled, then go to WRITE.
  - WRITE: out_we=1, out_idx=neu for 1 cycle (activation is combinational downstream). If neu==N_OUT-1 go to DONE, else neu+1 and go to CLR.
  - DONE: ack_layer=1. Stay while req=1; when req=0, go to IDLE (ack_layer falls the cycle after req falls).
  - ERR: err=1, ack_layer=1, same exit as DONE. err stays 1 until the next start.
- Handshake rules:
  - mac_req and add_req fall the cycle after the ack is sampled.
  - An ack seen outside MAC/BIAS is ignored.
  - req falling mid-run is ignored; the layer completes. If req is already 0 at DONE, ack_layer is high for exactly 1 cycle.
- Timeout: a wait counter clears on entry to MAC/BIAS and increments each cycle without the ack. On reaching TO_CYCLES, go to ERR. If the ack and expiry coincide, the ack wins.
- Index wrap: in and neu never exceed N_IN-1 and N_OUT-1; w_addr never exceeds N_IN*N_OUT-1.
- Latency with 1-cycle ack responders: per neuron 1 + 3*N_IN + 2 + 1 cycles. N_IN=N_OUT=2 gives 10 per neuron; ack_layer rises on cycle 21 after the start edge.

Test Plan:
- Nominal run (N_IN=2, N_OUT=2, acks 1 cycle after req): w_addr sequence 0,1,2,3; acc_clr and out_we 2 each; out_idx 0 then 1; ack_layer rises cycle 21, err=0.
- Slow responder (mac_ack 5 cycles after mac_req): mac_req held exactly 5 cycles each time; total latency +12 cycles; results and order unchanged.
- Timeout (mac_ack never returned on w_addr=2): ERR reached after 15 MAC cycles; err=1, ack_layer=1, no out_we for neuron 1. Next req clears err.
- Reset mid-run (rst asserted in BIAS of neuron 0): next cycle all outputs 0, state IDLE. A fresh req yields a full nominal run.
- Handshake edges: req dropped during neuron 1 gives a 1-cycle ack_layer pulse. Spurious mac_ack in ADDR is ignored (in_idx does not advance). mac_ack on the timeout cycle completes normally.
- Back-to-back runs: req high, drop after ack, reassert next cycle; second run identical to the first, no stale indices.
